// File: rtl/hex_scroll_engine.sv
// -----------------------------------------------------------------------------
// hex_scroll_engine
//
// Step-timed message scroller for NUM_DIGITS seven-segment digits. A prescaler
// produces one scroll tick every DIV_COUNT clocks while running. A writable
// MSG_LEN x 4-bit message store is read through a rotating pointer. The result
// is a packed vector of 4-bit symbol codes; external per-digit decoders turn
// the codes into segments.
//
// Optional feature: define HEX_SCROLL_BLINK_EN to add the `blink` input. When
// blink=1, the display blanks on every other scroll step. The pointer still
// advances on every step.
//
// Ports:
//   clk      - system clock
//   resetn   - asynchronous active-low reset
//   start    - pulse: (re)start scrolling from pointer 0
//   stop     - pulse: return to idle (highest priority)
//   hold     - level: freeze scrolling while high
//   dir      - 0 = text moves left (ptr++), 1 = text moves right (ptr--)
//   wr_en    - message write strobe
//   wr_addr  - message write address (addresses >= MSG_LEN are ignored)
//   wr_data  - symbol code to write
//   blink    - (HEX_SCROLL_BLINK_EN only) blank on alternate steps
//   digits   - packed symbol codes; digit i at [4i+3:4i], digit 0 = rightmost
//   step     - one-cycle pulse on each pointer advance
//   wrap     - one-cycle pulse when the pointer wraps
//   busy     - high while running or holding
// -----------------------------------------------------------------------------
module hex_scroll_engine #(
  parameter int         NUM_DIGITS = 8,
  parameter int         MSG_LEN    = 16,
  parameter int         DIV_COUNT  = 50000000,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    hold,
  input  logic                    dir,
  input  logic                    wr_en,
  input  logic [7:0]              wr_addr,
  input  logic [3:0]              wr_data,
`ifdef HEX_SCROLL_BLINK_EN
  input  logic                    blink,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    step,
  output logic                    wrap,
  output logic                    busy
);

  localparam int PTR_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int CNT_W = $clog2(DIV_COUNT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [3:0]              msg_q [MSG_LEN];
  logic [3:0]              msg_d [MSG_LEN];
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic                    step_q, step_d;
  logic                    wrap_q, wrap_d;
  logic                    busy_q, busy_d;
  logic                    tick;
  logic                    blank_phase;
  logic [PTR_W-1:0]        idx;

  // A tick only counts in a cycle that is not being overridden by stop/start.
  // Those commands reset the pointer instead.
  assign tick = (state_q == ST_RUN) && (cnt_q == CNT_LAST) && !stop && !start;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples
  // the pre-edge values of the others, whatever order the blocks run in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: stop > start > hold.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of a combinational block,
  // so that no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = hold ? ST_HOLD : ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (stop) state_d = ST_IDLE;
        else      state_d = hold ? ST_HOLD : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: prescaler, pointer, step/wrap, message store
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (stop || start || state_q == ST_IDLE) begin
      cnt_d = '0;
      ptr_d = '0;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        cnt_d  = '0;
        step_d = 1'b1;
        if (dir) begin
          wrap_d = (ptr_q == '0);
          ptr_d  = wrap_d ? PTR_LAST : ptr_q - PTR_W'(1);
        end else begin
          wrap_d = (ptr_q == PTR_LAST);
          ptr_d  = wrap_d ? '0 : ptr_q + PTR_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // The prescaler stays frozen in HOLD because no branch above changes it.
  end

  always_comb begin
    msg_d = msg_q;
    for (int j = 0; j < MSG_LEN; j++) begin
      if (wr_en && (int'(wr_addr) == j)) msg_d[j] = wr_data;
    end
  end

`ifdef HEX_SCROLL_BLINK_EN
  logic phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (stop || start || state_q == ST_IDLE) phase_d = 1'b0;
    else if (tick)                           phase_d = ~phase_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) phase_q <= 1'b0;
    else         phase_q <= phase_d;
  end

  assign blank_phase = blink & phase_q;
`else
  assign blank_phase = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output logic: registered display built from the current ptr and message
  // ---------------------------------------------------------------------------
  always_comb begin
    digits_d = {NUM_DIGITS{BLANK_CODE}};
    busy_d   = (state_d != ST_IDLE);
    idx      = '0;
    if (state_q != ST_IDLE && !blank_phase) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        // The leftmost digit shows msg[ptr]. Short messages repeat modulo MSG_LEN.
        idx = PTR_W'((int'(ptr_q) + NUM_DIGITS - 1 - i) % MSG_LEN);
        digits_d[4*i +: 4] = msg_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      ptr_q    <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
      digits_q <= {NUM_DIGITS{BLANK_CODE}};
      // NOTE: the message store is a flop array, not a RAM. Resetting it is
      // what makes a fresh start show a blank message.
      for (int j = 0; j < MSG_LEN; j++) msg_q[j] <= BLANK_CODE;
    end else begin
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      busy_q   <= busy_d;
      digits_q <= digits_d;
      msg_q    <= msg_d;
    end
  end

  assign digits = digits_q;
  assign step   = step_q;
  assign wrap   = wrap_q;
  assign busy   = busy_q;

endmodule

// File: doc/hex_scroll_engine.md
Name: hex_scroll_engine

Overview:
- Parameterised successor to the fixed "HELLO" scroller: a step-timed message scroller driving NUM_DIGITS seven-segment digits.
- Contains a prescaler, a writable MSG_LEN x 4-bit message store, a rotating read pointer and a run-control FSM.
- Outputs 4-bit symbol codes per digit, packed; the existing per-digit Decoder instances convert them to segments.
- Sits between the board top level (CLOCK_50, switches/keys) and the decoders.

Parameters:
- NUM_DIGITS, 8, number of displayed digits (>=1).
- MSG_LEN, 16, message store depth in symbols (>=1; may be less than, equal to or greater than NUM_DIGITS).
- DIV_COUNT, 50000000, clk cycles per scroll step (>=2; 1 Hz at 50 MHz).
- BLANK_CODE, 4'hF, symbol code the decoder renders as all segments off.

Ports:
- clk, input, 1, system clock (CLOCK_50 at top level).
- resetn, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse: begin scrolling from pointer 0.
- stop, input, 1, one-cycle pulse: return to IDLE.
- hold, input, 1, level: freeze scrolling while high.
- dir, input, 1, 0 = text moves left (pointer increments), 1 = text moves right (pointer decrements).
- wr_en, input, 1, message write strobe.
- wr_addr, input, 8, message write address.
- wr_data, input, 4, symbol code to write.
- digits, output, 4*NUM_DIGITS, packed symbol codes; digit i at [4i+3:4i]; digit 0 = rightmost (HEX0).
- step, output, 1, one-cycle pulse on each pointer advance.
- wrap, output, 1, one-cycle pulse when the pointer wraps.
- busy, output, 1, high in RUN or HOLD.

Behaviour:
- Reset (resetn=0, async): state=IDLE; ptr=0; prescaler=0; all message entries=BLANK_CODE; digits=all BLANK_CODE; step=wrap=busy=0.
- Prescaler: counts 0..DIV_COUNT-1 in RUN only.
  - tick is asserted when count==DIV_COUNT-1; the count then wraps to 0.
  - Frozen (value held) in HOLD; cleared in IDLE and on start.
- FSM states: IDLE, RUN, HOLD.
  - IDLE -> RUN on start; ptr and prescaler cleared.
  - RUN -> HOLD when hold=1; HOLD -> RUN when hold=0.
  - RUN/HOLD -> IDLE on stop; ptr is cleared.
  - start in RUN/HOLD restarts: ptr=0, prescaler=0, state=RUN (or HOLD if hold=1).
  - Priority: stop > start > hold.
  - A start pulse with hold=1 enters HOLD directly.
- Pointer: ptr width max(1, clog2(MSG_LEN)).
  - On tick, dir=0: ptr=(ptr+1) mod MSG_LEN.
  - On tick, dir=1: ptr=(ptr+MSG_LEN-1) mod MSG_LEN.
  - step pulses in the same cycle ptr updates.
  - wrap pulses when the update is MSG_LEN-1 -> 0 (dir=0) or 0 -> MSG_LEN-1 (dir=1).
  - MSG_LEN=1: ptr stays 0; step and wrap both pulse on every tick.
  - dir is sampled only at tick; a change between ticks takes effect at the next tick.
- Display mapping: digit i shows msg[(ptr + NUM_DIGITS-1-i) mod MSG_LEN], so the leftmost digit shows msg[ptr].
  - The index wraps modulo MSG_LEN, so short messages repeat across the display.
  - In IDLE, digits = all BLANK_CODE regardless of message contents.
- Output timing: digits is registered and reflects the ptr and message contents of the previous cycle.
  - Latency: 1 cycle after a ptr update or a message write.
  - A write to a currently displayed entry is visible 1 cycle after the write edge.
- Writes: accepted in any state, at the rising edge when wr_en=1.
  - wr_addr >= MSG_LEN is ignored with no side effects.
  - A write in the same cycle as a tick completes; the next digits update uses the new data.
- busy = (state != IDLE), registered with state.
- Reset mid-operation aborts immediately to the reset values above.

Optional Feature:
- Macro: HEX_SCROLL_BLINK_EN.
- Defined:
  - Adds input port blink (1 bit) and an internal phase bit that toggles on every tick while in RUN.
  - Phase is cleared in IDLE and on start, and held in HOLD.
  - When blink=1 and phase=1, digits = all BLANK_CODE; the pointer still advances normally.
  - When blink=0, output matches the non-blink build.
- Undefined: no blink port, no phase register; behaviour exactly as above.

Test Plan:
- Common setup: NUM_DIGITS=4, MSG_LEN=6, DIV_COUNT=4.
- Reset then idle: after resetn low->high with no stimulus for 50 cycles -> digits=16'hFFFF, busy=0, step never pulses.
- Left scroll: write msg = {1,2,3,4,5,6} to addresses 0..5, pulse start, dir=0.
  - Before the first tick: digits=16'h1234.
  - step every 4 cycles; successive digits 16'h2345, 16'h3456, 16'h4561, 16'h5612, 16'h6123, 16'h1234.
  - wrap pulses on the 5->0 step.
- Right scroll and direction change: same message, dir=1 from start.
  - First step gives ptr=5 with wrap=1; digits=16'h6123.
  - dir set to 0 mid-step: the next step gives ptr=0; digits=16'h1234.
- Hold and stop: hold=1 for 10 cycles mid-run -> digits stable, no step, busy=1.
  - After hold drops, the next step arrives after the remaining prescaler count.
  - Pulsing start and stop together -> IDLE, digits=16'hFFFF one cycle later.
- Write edge cases: wr_addr=6 with wr_data=0 -> no digit changes.
  - Writing addr 0 = 4'hA while ptr=0 -> digits=16'hA234 one cycle later.
  - Asserting resetn=0 mid-run -> immediate blank output, ptr=0.
- Blink (HEX_SCROLL_BLINK_EN defined, blink=1): outputs alternate 16'hFFFF and message text on successive steps; the pointer sequence is identical to the left-scroll case.
